// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : EX/MEM pipeline register plus data-memory access stage with
//           req/ready handshake, timeout and MEM/WB writeback register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_rs2_data,
  input  logic [4:0]  EX_rd,
  input  logic        EX_memread,
  input  logic        EX_memwrite,
  input  logic        EX_memtoreg,
  input  logic        EX_regwrite,
  input  logic        EX_stall,
  output logic [31:0] EX_MEM_ALU_result,
  output logic [4:0]  EX_MEM_rd,
  output logic        EX_MEM_regwrite,
  output logic        EX_MEM_memtoreg,
  output logic [31:0] MEM_WB_result,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite,
  output logic        MEM_stall,
  output logic        MEM_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(DMEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        stall;
  logic        memop;
  logic        timeout_hit;

  logic [31:0] exmem_alu_q;
  logic [31:0] exmem_rs2_q;
  logic [4:0]  exmem_rd_q;
  logic        exmem_memread_q;
  logic        exmem_memwrite_q;
  logic        exmem_memtoreg_q;
  logic        exmem_regwrite_q;

  logic [31:0] memwb_result_q;
  logic [4:0]  memwb_rd_q;
  logic        memwb_regwrite_q;

  assign memop       = exmem_memread_q | exmem_memwrite_q;
  // Counter holds the number of BUSY cycles already spent before this one.
  assign timeout_hit = ({1'b0, cnt_q} + 17'd1) == TIMEOUT_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_alu_q      <= '0;
      exmem_rs2_q      <= '0;
      exmem_rd_q       <= '0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_regwrite_q <= 1'b0;
    end else if (!stall) begin
      if (EX_stall) begin
        exmem_alu_q      <= '0;
        exmem_rs2_q      <= '0;
        exmem_rd_q       <= '0;
        exmem_memread_q  <= 1'b0;
        exmem_memwrite_q <= 1'b0;
        exmem_memtoreg_q <= 1'b0;
        exmem_regwrite_q <= 1'b0;
      end else begin
        exmem_alu_q      <= EX_ALU_result;
        exmem_rs2_q      <= EX_rs2_data;
        exmem_rd_q       <= EX_rd;
        exmem_memread_q  <= EX_memread;
        exmem_memwrite_q <= EX_memwrite;
        exmem_memtoreg_q <= EX_memtoreg;
        exmem_regwrite_q <= EX_regwrite;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        // A response arriving on the timeout cycle still counts as success.
        if (dmem_ready) begin
          rdata_d = dmem_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Bubbles during a stall keep a held instruction from writing back twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_result_q   <= '0;
      memwb_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
    end else if (stall) begin
      memwb_result_q   <= '0;
      memwb_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
    end else begin
      memwb_result_q   <= exmem_memtoreg_q ? rdata_q : exmem_alu_q;
      memwb_rd_q       <= exmem_rd_q;
      memwb_regwrite_q <= exmem_regwrite_q & (exmem_rd_q != 5'd0);
    end
  end

  assign EX_MEM_ALU_result = exmem_alu_q;
  assign EX_MEM_rd         = exmem_rd_q;
  assign EX_MEM_regwrite   = exmem_regwrite_q;
  assign EX_MEM_memtoreg   = exmem_memtoreg_q;
  assign MEM_WB_result     = memwb_result_q;
  assign MEM_WB_rd         = memwb_rd_q;
  assign MEM_WB_regwrite   = memwb_regwrite_q;
  assign MEM_stall         = stall;
  assign MEM_fault         = fault_q;
  assign dmem_req          = (state_q == BUSY);
  assign dmem_we           = exmem_memwrite_q;
  assign dmem_addr         = exmem_alu_q;
  assign dmem_wdata        = exmem_rs2_q;

endmodule

`default_nettype wire
